// File: rtl/humidity_pkg.sv
// Shared types, display constants and the cyclic set-bit search for the humidity monitor.
package humidity_pkg;

    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_WARN = 2'b01,
        ST_CRIT = 2'b10
    } state_t;

    localparam int MAX_AREAS = 10;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_CRIT  = 8'h79;

    localparam logic [7:0] DIGIT [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

    // First set bit strictly after cur, wrapping modulo n; returns 0 if none is set.
    // Scanning from the far end lets the nearest hit overwrite farther ones.
    function automatic int nextSetBit(input logic [MAX_AREAS-1:0] mask,
                                      input int cur,
                                      input int n);
        int result;
        int idx;
        result = 0;
        for (int k = MAX_AREAS; k >= 1; k--) begin
            if (k <= n) begin
                idx = (cur + k) % n;
                if (mask[idx]) begin
                    result = idx;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/humidity_monitor_area_filter.sv
// Per-area debounce: a dry flag needs FILTER_CYCLES consecutive dry samples, wet clears at once.
module area_filter #(
    parameter int FILTER_CYCLES = 3
) (
    input  logic clk_2,
    input  logic reset,
    input  logic dry_in,
    output logic dry_flag
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    // The flag rises on the same edge the counter reaches its saturation value.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_cnt    <= '0;
            dry_flag <= 1'b0;
        end else if (!dry_in) begin
            r_cnt    <= '0;
            dry_flag <= 1'b0;
        end else begin
            if (r_cnt < CW'(FILTER_CYCLES)) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_cnt >= CW'(FILTER_CYCLES - 1)) begin
                dry_flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/humidity_monitor.sv
// Multi-area soil humidity monitor: debounced dry flags, OK/WARN/CRIT classification,
// rotating 7-segment display of dry areas and a sticky acknowledgeable alarm.
module humidity_monitor
    import humidity_pkg::*;
#(
    parameter int NAREAS        = 4,
    parameter int FILTER_CYCLES = 3,
    parameter int DWELL         = 4,
    parameter int CNT_W         = 8
) (
    input  logic                      clk_2,
    input  logic                      reset,
    input  logic [NAREAS-1:0]         dry_in,
    input  logic                      ack,
    output logic [7:0]                seg,
    output logic                      alarm,
    output logic [1:0]                state_o,
    output logic [NAREAS-1:0]         dry_mask,
    output logic [$clog2(NAREAS)-1:0] cur_area,
    output logic [CNT_W-1:0]          crit_count
);

    localparam int AW = $clog2(NAREAS);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [NAREAS-1:0]    w_dryMask;
    logic [MAX_AREAS-1:0] w_maskExt;
    state_t               w_nextState;
    logic [7:0]           w_seg;

    state_t               r_state;
    logic [AW-1:0]        r_curArea;
    logic [DW-1:0]        r_dwell;
    logic                 r_alarm;
    logic [CNT_W-1:0]     r_critCount;

    for (genvar i = 0; i < NAREAS; i++) begin : g_filter
        area_filter #(
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_filter (
            .clk_2   (clk_2),
            .reset   (reset),
            .dry_in  (dry_in[i]),
            .dry_flag(w_dryMask[i])
        );
    end

    always_comb begin
        w_maskExt = '0;
        w_maskExt[NAREAS-1:0] = w_dryMask;
    end

    always_comb begin
        w_nextState = ST_WARN;
        if (w_dryMask == '0) begin
            w_nextState = ST_OK;
        end else if (&w_dryMask) begin
            w_nextState = ST_CRIT;
        end
    end

    // Classification FSM, alarm latch, CRIT entry counter and WARN rotation share one register block.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state     <= ST_OK;
            r_curArea   <= '0;
            r_dwell     <= '0;
            r_alarm     <= 1'b0;
            r_critCount <= '0;
        end else begin
            r_state <= w_nextState;

            if (w_nextState == ST_CRIT && r_state != ST_CRIT) begin
                r_alarm <= 1'b1;
                if (r_critCount != '1) begin
                    r_critCount <= r_critCount + 1'b1;
                end
            end else if (ack && r_state != ST_CRIT) begin
                r_alarm <= 1'b0;
            end

            if (w_nextState != ST_WARN) begin
                r_curArea <= '0;
                r_dwell   <= '0;
            end else if (r_state != ST_WARN) begin
                r_curArea <= AW'(nextSetBit(w_maskExt, NAREAS - 1, NAREAS));
                r_dwell   <= '0;
            end else if (r_dwell == DW'(DWELL - 1) || !w_maskExt[r_curArea]) begin
                r_curArea <= AW'(nextSetBit(w_maskExt, int'(r_curArea), NAREAS));
                r_dwell   <= '0;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    always_comb begin
        w_seg = SEG_BLANK;
        case (r_state)
            ST_WARN: w_seg = DIGIT[r_curArea];
            ST_CRIT: w_seg = SEG_CRIT;
            default: w_seg = SEG_BLANK;
        endcase
    end

    assign seg        = w_seg;
    assign alarm      = r_alarm;
    assign state_o    = r_state;
    assign dry_mask   = w_dryMask;
    assign cur_area   = r_curArea;
    assign crit_count = r_critCount;

endmodule

// File: tb/tb_humidity_monitor.sv
// Directed checks of the humidity monitor: reset, debounce, rotation, alarm handling
// and critical-counter saturation on a narrow-counter second instance.
module tb_humidity_monitor;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [3:0] dry_in;
    logic       ack;
    logic [7:0] seg;
    logic       alarm;
    logic [1:0] state_o;
    logic [3:0] dry_mask;
    logic [1:0] cur_area;
    logic [7:0] crit_count;

    logic [3:0] dry2;
    logic       ack2;
    logic [7:0] seg2;
    logic       alarm2;
    logic [1:0] state2;
    logic [3:0] mask2;
    logic [1:0] cur2;
    logic [1:0] count2;

    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;

    logic [3:0] glitch [5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100};

    humidity_monitor dut (
        .clk_2     (clk_2),
        .reset     (reset),
        .dry_in    (dry_in),
        .ack       (ack),
        .seg       (seg),
        .alarm     (alarm),
        .state_o   (state_o),
        .dry_mask  (dry_mask),
        .cur_area  (cur_area),
        .crit_count(crit_count)
    );

    humidity_monitor #(.CNT_W(2)) dut2 (
        .clk_2     (clk_2),
        .reset     (reset),
        .dry_in    (dry2),
        .ack       (ack2),
        .seg       (seg2),
        .alarm     (alarm2),
        .state_o   (state2),
        .dry_mask  (mask2),
        .cur_area  (cur2),
        .crit_count(count2)
    );

    always #5 clk_2 = ~clk_2;

    task automatic applyStimulus(input logic [3:0] dry, input logic ackV, input int n);
        dry_in = dry;
        ack    = ackV;
        repeat (n) begin
            @(posedge clk_2);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        dry2  = 4'b0000;
        ack2  = 1'b0;
        applyStimulus(4'b1111, 1'b0, 2);
        checkOutput("rst_mask", dry_mask, 4'b0000);
        checkOutput("rst_state", state_o, 2'b00);
        checkOutput("rst_seg", seg, 8'h00);
        checkOutput("rst_alarm", alarm, 1'b0);
        checkOutput("rst_count", crit_count, 8'd0);
        checkOutput("rst_cur", cur_area, 2'd0);

        reset = 1'b0;
        applyStimulus(4'b1111, 1'b0, 3);
        checkOutput("lat_mask", dry_mask, 4'b1111);
        checkOutput("lat_state_ok", state_o, 2'b00);
        applyStimulus(4'b1111, 1'b0, 1);
        checkOutput("crit_state", state_o, 2'b10);
        checkOutput("crit_seg", seg, 8'h79);
        checkOutput("crit_alarm", alarm, 1'b1);
        checkOutput("crit_count1", crit_count, 8'd1);

        // Glitchy sensor never accumulates three consecutive dry samples.
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(glitch[i], 1'b0, 1);
            checkOutput("glitch_mask", dry_mask, 4'b0000);
            checkOutput("glitch_state", state_o, 2'b00);
        end

        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1);
        reset = 1'b0;
        applyStimulus(4'b0101, 1'b0, 3);
        checkOutput("rot_mask", dry_mask, 4'b0101);
        checkOutput("rot_pre_state", state_o, 2'b00);
        for (int e = 4; e <= 12; e++) begin
            applyStimulus(4'b0101, 1'b0, 1);
            checkOutput("rot_state", state_o, 2'b01);
            checkOutput("rot_seg", seg, (e >= 8 && e <= 11) ? 8'h5B : 8'h3F);
        end
        applyStimulus(4'b0101, 1'b0, 5);
        checkOutput("rot_cur2", cur_area, 2'd2);
        applyStimulus(4'b0001, 1'b0, 1);
        checkOutput("drop_cur_hold", cur_area, 2'd2);
        applyStimulus(4'b0001, 1'b0, 1);
        checkOutput("drop_cur0", cur_area, 2'd0);
        checkOutput("drop_seg", seg, 8'h3F);

        applyStimulus(4'b1111, 1'b0, 3);
        checkOutput("al_pre_state", state_o, 2'b01);
        checkOutput("al_pre_alarm", alarm, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1);
        checkOutput("al_crit", state_o, 2'b10);
        checkOutput("al_set", alarm, 1'b1);
        checkOutput("al_count1", crit_count, 8'd1);
        applyStimulus(4'b1111, 1'b1, 1);
        checkOutput("al_ack_in_crit", alarm, 1'b1);
        applyStimulus(4'b1110, 1'b0, 2);
        checkOutput("al_warn", state_o, 2'b01);
        checkOutput("al_warn_alarm", alarm, 1'b1);
        checkOutput("al_warn_seg", seg, 8'h06);
        applyStimulus(4'b1110, 1'b1, 1);
        checkOutput("al_cleared", alarm, 1'b0);
        applyStimulus(4'b1111, 1'b0, 4);
        checkOutput("al_recrit", state_o, 2'b10);
        checkOutput("al_count2", crit_count, 8'd2);
        checkOutput("al_reset", alarm, 1'b1);

        // Ack held high across a WARN->CRIT entry and the following exit.
        applyStimulus(4'b1110, 1'b0, 2);
        checkOutput("pr_warn", state_o, 2'b01);
        checkOutput("pr_warn_alarm", alarm, 1'b1);
        applyStimulus(4'b1111, 1'b1, 1);
        checkOutput("pr_ack_clear", alarm, 1'b0);
        applyStimulus(4'b1111, 1'b1, 2);
        checkOutput("pr_still_warn", state_o, 2'b01);
        checkOutput("pr_still_low", alarm, 1'b0);
        applyStimulus(4'b1111, 1'b1, 1);
        checkOutput("pr_enter_crit", state_o, 2'b10);
        checkOutput("pr_set_wins", alarm, 1'b1);
        checkOutput("pr_count3", crit_count, 8'd3);
        applyStimulus(4'b1110, 1'b1, 1);
        checkOutput("pr_hold_crit", alarm, 1'b1);
        applyStimulus(4'b1110, 1'b1, 1);
        checkOutput("pr_exit_state", state_o, 2'b01);
        checkOutput("pr_exit_alarm", alarm, 1'b1);
        applyStimulus(4'b1110, 1'b1, 1);
        checkOutput("pr_after_exit", alarm, 1'b0);

        for (int k = 1; k <= 5; k++) begin
            dry2 = 4'b1111;
            applyStimulus(4'b0000, 1'b0, 4);
            checkOutput("sat_crit", state2, 2'b10);
            checkOutput("sat_count", count2, (k < 3) ? k : 3);
            dry2 = 4'b1110;
            applyStimulus(4'b0000, 1'b0, 2);
            checkOutput("sat_warn", state2, 2'b01);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/humidity_monitor.md
Name: humidity_monitor

Overview:
Parametrised multi-area soil-humidity monitor for the lab board. NAREAS raw dry/wet sensor bits are debounced per area, and a state machine classifies the field as OK, WARN or CRIT. The 7-segment display rotates through the dry areas, and a sticky, acknowledgeable alarm drives a LED. It sits between SWI (sensors, ack) and SEG/LED in top.

Parameters:
NAREAS, 4, number of monitored areas; legal range 2..10, one decimal digit per area.
FILTER_CYCLES, 3, consecutive dry samples needed to flag an area; legal range ≥1.
DWELL, 4, cycles each dry area stays on the display in WARN; legal range ≥1.
CNT_W, 8, width of the critical-event counter.

Ports:
clk_2  in  1  board clock.
reset  in  1  synchronous, active-high reset.
dry_in  in  NAREAS  raw sensor bits; 1 = area dry.
ack  in  1  alarm acknowledge, level-sampled.
seg  out  8  7-seg pattern, gfedcba in bits 6:0; bit 7 (dp) is always 0.
alarm  out  1  sticky critical alarm.
state_o  out  2  encoding: 00 OK, 01 WARN, 10 CRIT.
dry_mask  out  NAREAS  filtered dry flags.
cur_area  out  $clog2(NAREAS)  area index currently displayed.
crit_count  out  CNT_W  number of entries into CRIT, saturating.

Behaviour:
- Reset (synchronous, highest priority): all filter counters 0, dry_mask 0, state OK, cur_area 0, dwell 0, alarm 0, crit_count 0, seg 8'h00. Reset asserted mid-rotation or in CRIT clears everything on the next edge.
- Filter, per area i:
  - dry_in[i]=1: cnt[i] increments, saturating at FILTER_CYCLES.
  - dry_in[i]=0: cnt[i]=0 and dry_mask[i]=0 on the same edge. Wet clears immediately; the filter is asymmetric.
  - dry_mask[i] registers 1 on the edge where cnt[i] reaches FILTER_CYCLES.
  - Latency: dry_in high before edge k gives dry_mask high after edge k+FILTER_CYCLES-1.
- State machine, next state from the registered dry_mask, so state_o lags dry_mask by one edge:
  - mask==0 → OK.
  - mask all-ones → CRIT.
  - otherwise → WARN.
  - Any state may move to any state in one cycle, e.g. OK→CRIT directly.
- Rotation, active in WARN only:
  - On entry to WARN: cur_area = lowest set bit of dry_mask, dwell=0.
  - Each WARN cycle: if dwell==DWELL-1, or dry_mask[cur_area]==0, then cur_area = next set bit strictly above cur_area, cyclic with wrap to 0, and dwell=0. Otherwise dwell++.
  - With a single flagged area, cur_area stays on it and dwell keeps cycling.
  - Outside WARN, cur_area and dwell hold 0.
- seg is combinational from the registers:
  - OK → SEG_BLANK 8'h00.
  - WARN → DIGIT[cur_area].
  - CRIT → SEG_CRIT 8'h79 ('E').
- Alarm:
  - Set on the edge state enters CRIT.
  - Cleared on an edge where ack=1 and state≠CRIT.
  - ack while in CRIT is ignored.
  - Entry into CRIT and ack on the same edge: the set wins.
- crit_count increments on every OK/WARN→CRIT transition and saturates at 2^CNT_W-1.

Decomposition:
- Package humidity_pkg:
  - state_t enum {ST_OK=2'b00, ST_WARN=2'b01, ST_CRIT=2'b10}.
  - SEG_BLANK, SEG_CRIT.
  - DIGIT[0:9] standard codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Sub-module area_filter: one per area, instantiated by generate. Parameter FILTER_CYCLES; ports clk_2, reset, dry_in, dry_flag.
- The next-set-bit search is a function in the package.

Test Plan:
- Reset behaviour: reset=1 for 2 cycles with dry_in=4'b1111 → all outputs 0, seg=8'h00. Release → dry_mask=1111 after 3 edges, state_o=10 one edge later, seg=8'h79, alarm=1, crit_count=1.
- Filter glitch rejection: dry_in[2] high for 2 cycles, low for 1, high for 2 → dry_mask stays 0000, state OK throughout.
- Rotation: dry_mask reaches 0101 → WARN, seg=3F for 4 cycles, then 5B for 4 cycles, then 3F again. Mid-dwell, dry_in[2]=0 → cur_area goes back to 0 within 2 edges.
- Alarm latch and acknowledge: reach CRIT, then ack=1 → alarm stays 1. Drop dry_in[0] → WARN with alarm still 1. Assert ack=1 → alarm=0 on the next edge. Re-enter CRIT → crit_count=2.
- Same-edge set/clear priority: hold ack=1 continuously while entering CRIT from WARN → alarm=1 on the entry edge. Leaving CRIT with ack still 1 → alarm clears on the following edge.
- Counter saturation: CNT_W=2, toggle all-dry/one-wet 5 times → crit_count=3, no wrap.
